// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared RAM status and arbiter state types
package cpu_types_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, DGNT, IGNT} arb_state_t;
  localparam int ARB_FAIR_LIMIT = 4;
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: icache/dcache/RAM bus bundle seen by the arbiter
interface cache_mem_arbiter_if
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic iREN, iwait, dREN, dWEN, dwait, ramREN, ramWEN;
  logic [ADDR_W-1:0] iaddr, daddr, ramaddr;
  logic [DATA_W-1:0] iload, dload, dstore, ramstore, ramload;
  ramstate_t ramstate;
  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: single-port RAM arbiter, dcache priority with burst lock; ARB_FAIRNESS_EN adds an icache fairness counter
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef ARB_FAIRNESS_EN
  , parameter int FAIR_LIMIT = ARB_FAIR_LIMIT
`endif
) (
  input logic CLK,
  input logic nRST,
  cache_mem_arbiter_if.master bus
);
  arb_state_t state, next_state;
  logic d_req, access, fair_hit;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] store;
  assign d_req  = bus.dREN | bus.dWEN;
  assign access = bus.ramstate == ACCESS;
`ifdef ARB_FAIRNESS_EN
  localparam int CW = $clog2(FAIR_LIMIT + 1);
  logic [CW-1:0] fair_cnt;
  assign fair_hit = state == DGNT && access && bus.iREN && fair_cnt == CW'(FAIR_LIMIT - 1);
  // count dcache words served while icache waits; clear when icache gets its turn
  always_ff @(posedge CLK) begin
    if (!nRST || state == IDLE || fair_hit || (state == IGNT && access))
      fair_cnt <= '0;
    else if (state == DGNT && access && bus.iREN && fair_cnt != CW'(FAIR_LIMIT))
      fair_cnt <= fair_cnt + 1'b1;
  end
`else
  assign fair_hit = 1'b0;
`endif
  // grant state register
  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end
  // next grant: dcache holds the RAM for its whole burst, icache gets one word
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = d_req ? DGNT : (bus.iREN ? IGNT : IDLE);
      DGNT:    next_state = fair_hit ? IGNT : (d_req ? DGNT : IDLE);
      IGNT:    next_state = (access || !bus.iREN) ? (d_req ? DGNT : IDLE) : IGNT;
      default: next_state = IDLE;
    endcase
  end
  // RAM side mux and per-cache wait handshakes off the registered grant
  always_comb begin
    addr  = state == DGNT ? bus.daddr : (state == IGNT ? bus.iaddr : '0);
    store = state == DGNT ? bus.dstore : '0;
  end
  assign bus.ramaddr  = addr;
  assign bus.ramstore = store;
  assign bus.ramWEN   = state == DGNT && bus.dWEN;
  assign bus.ramREN   = state == DGNT ? (bus.dREN && !bus.dWEN) : (state == IGNT && bus.iREN);
  assign bus.dwait    = !(state == DGNT && access);
  assign bus.iwait    = !(state == IGNT && access);
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: vector table, corner sequences and random traffic against a grant-owner model
module tb_cache_mem_arbiter;
  import cpu_types_pkg::*;
`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int FL = ARB_FAIR_LIMIT;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  cache_mem_arbiter dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  int checks = 0, errors = 0;
  int owner = 0, fcnt = 0;
  int dcomp = 0, icomp = 0, first_i_d = -1, igrant = 0;
  logic [31:0] dq_addr[$];

  typedef struct {
    logic nrst, iren, dren, dwen;
    logic [31:0] ia, da, ds;
    ramstate_t rs;
    logic [31:0] ld;
    logic ren, wen;
    logic [31:0] addr, st;
    logic iw, dw;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string nm, input logic [131:0] got, input logic [131:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [131:0] dut_out();
    return {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.iwait, bus.dwait, bus.iload, bus.dload};
  endfunction

  function automatic logic [131:0] model_out();
    logic ren, wen, iw, dw, acc;
    logic [31:0] a, s;
    acc = bus.ramstate == ACCESS;
    ren = owner == 1 ? (bus.dREN & ~bus.dWEN) : (owner == 2 ? bus.iREN : 1'b0);
    wen = owner == 1 ? bus.dWEN : 1'b0;
    a   = owner == 1 ? bus.daddr : (owner == 2 ? bus.iaddr : 32'h0);
    s   = owner == 1 ? bus.dstore : 32'h0;
    iw  = !(owner == 2 && acc);
    dw  = !(owner == 1 && acc);
    return {ren, wen, a, s, iw, dw, bus.ramload, bus.ramload};
  endfunction

  task automatic step_model();
    logic acc, dq;
    acc = bus.ramstate == ACCESS;
    dq  = bus.dREN | bus.dWEN;
    if (!nRST) begin
      owner = 0;
      fcnt  = 0;
    end else if (owner == 0) begin
      owner = dq ? 1 : (bus.iREN ? 2 : 0);
      fcnt  = 0;
    end else if (owner == 1) begin
      if (FAIR && acc && bus.iREN && fcnt + 1 >= FL) begin
        owner = 2;
        fcnt  = 0;
      end else begin
        if (acc && bus.iREN && fcnt < FL) fcnt++;
        owner = dq ? 1 : 0;
      end
    end else begin
      if (acc) fcnt = 0;
      if (acc || !bus.iREN) owner = dq ? 1 : 0;
    end
  endtask

  task automatic tick(input string nm);
    #1;
    chk(nm, dut_out(), model_out());
    if (!bus.dwait) begin
      dcomp++;
      dq_addr.push_back(bus.ramaddr);
    end
    if (!bus.iwait) begin
      if (icomp == 0) first_i_d = dcomp;
      icomp++;
    end
    if (bus.ramREN && bus.ramaddr == bus.iaddr && bus.ramaddr != bus.daddr) igrant++;
    step_model();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drive(input logic n, ir, dr, dw, input logic [31:0] ia, da, ds, input ramstate_t rs, input logic [31:0] ld);
    nRST = n; bus.iREN = ir; bus.dREN = dr; bus.dWEN = dw;
    bus.iaddr = ia; bus.daddr = da; bus.dstore = ds; bus.ramstate = rs; bus.ramload = ld;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h100, 32'h0, FREE,   32'h0,    1'b0, 1'b0, 32'h0,    32'h0, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h100, 32'h0, FREE,   32'h0,    1'b0, 1'b0, 32'h0,    32'h0, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h100, 32'h0, FREE,   32'h0,    1'b0, 1'b0, 32'h0,    32'h0, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h100, 32'h0, BUSY,   32'h0,    1'b1, 1'b0, 32'h100,  32'h0, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h100, 32'h0, BUSY,   32'h0,    1'b1, 1'b0, 32'h100,  32'h0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h100, 32'h0, ACCESS, 32'hdead, 1'b1, 1'b0, 32'h100,  32'h0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h100, 32'h0, FREE,   32'h0,    1'b0, 1'b0, 32'h100,  32'h0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h100, 32'h0, FREE,   32'h0,    1'b0, 1'b0, 32'h0,    32'h0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h100, 32'h0, BUSY,   32'h0,    1'b1, 1'b0, 32'h40,   32'h0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h100, 32'h0, ACCESS, 32'h1234, 1'b1, 1'b0, 32'h40,   32'h0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h3100, 32'h5, FREE,  32'h0,    1'b0, 1'b0, 32'h0,    32'h0, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h3100, 32'h5, BUSY,  32'h0,    1'b0, 1'b1, 32'h3100, 32'h5, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h3100, 32'h5, ACCESS, 32'h77,  1'b0, 1'b1, 32'h3100, 32'h5, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h3100, 32'h5, FREE,  32'h0,    1'b0, 1'b0, 32'h3100, 32'h5, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h3100, 32'h5, FREE,  32'h0,    1'b0, 1'b0, 32'h0,    32'h0, 1'b1, 1'b1};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE, 32'h0);
    @(posedge CLK);
    @(negedge CLK);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].nrst, tbl[i].iren, tbl[i].dren, tbl[i].dwen, tbl[i].ia, tbl[i].da, tbl[i].ds, tbl[i].rs, tbl[i].ld);
      #1;
      chk($sformatf("vec%0d", i), dut_out(),
          {tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].st, tbl[i].iw, tbl[i].dw, tbl[i].ld, tbl[i].ld});
      step_model();
      @(posedge CLK);
      @(negedge CLK);
    end

    dq_addr.delete();
    igrant = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h200, 32'hAAAA, FREE, 32'h0);
    tick("burst_idle");
    for (int w = 0; w < 4; w++) begin
      bus.dWEN   = w < 2;
      bus.dREN   = w >= 2;
      bus.daddr  = (w < 2 ? 32'h200 : 32'h300) + 32'(4 * (w % 2));
      bus.dstore = w == 0 ? 32'hAAAA : (w == 1 ? 32'hBBBB : 32'h0);
      bus.ramstate = BUSY;
      tick("burst_busy");
      bus.ramstate = ACCESS;
      bus.ramload  = 32'(w + 1);
      tick("burst_acc");
    end
    chk("burst_seq", dq_addr.size() == 4 ? {dq_addr[0], dq_addr[1], dq_addr[2], dq_addr[3]} : 128'h0,
        {32'h200, 32'h204, 32'h300, 32'h304});
    chk("burst_no_igrant", 132'(igrant), 132'(0));
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h304, 32'h0, FREE, 32'h0);
    tick("burst_tail");
    bus.ramstate = BUSY;
    for (int k = 0; k < 3; k++) tick("burst_igrant");
    bus.ramstate = ACCESS;
    tick("burst_icomp");
    bus.iREN = 1'b0;
    bus.ramstate = FREE;
    for (int k = 0; k < 3; k++) tick("drain");

    icomp = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, FREE, 32'h0);
    tick("err_idle");
    bus.ramstate = ERROR;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("err_hold", {bus.ramREN, bus.ramaddr, bus.iwait}, {1'b1, 32'h80, 1'b1});
      tick("err");
    end
    bus.iREN = 1'b0;
    tick("err_drop");
    tick("err_after");
    chk("err_no_icomp", 132'(icomp), 132'(0));

    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h500, 32'h9, FREE, 32'h0);
    tick("rst_idle");
    bus.ramstate = BUSY;
    tick("rst_dgnt");
    nRST = 1'b0;
    tick("rst_edge");
    #1;
    chk("rst_abort", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait}, 4'b0011);
    nRST = 1'b1;
    tick("rst_release");
    bus.dWEN = 1'b0;
    for (int k = 0; k < 2; k++) tick("drain");

    dcomp = 0; icomp = 0; first_i_d = -1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h600, 32'h0, ACCESS, 32'h55);
    for (int c = 0; c < 200 && dcomp < 20; c++) tick("fair");
    chk("fair_dwords", 132'(dcomp), 132'(20));
    chk("fair_icomp", 132'(icomp), 132'(FAIR ? (20 - 1) / FL : 0));
    chk("fair_first", 132'(first_i_d), 132'(FAIR ? FL : -1));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE, 32'h0);
    for (int k = 0; k < 3; k++) tick("drain");

    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 29) != 0, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
            $urandom, $urandom, $urandom, ramstate_t'($urandom_range(0, 3)), $urandom);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
